// File: rtl/lcd_pkg.sv
// Shared types, constants and DDRAM address helpers for the LCD bus receiver.
package lcd_pkg;

    typedef enum logic [1:0] {
        INIT8,
        HI,
        LO
    } lcd_state_e;

    localparam logic [7:0] CMD_CLEAR  = 8'h01;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] CMD_FSET4  = 8'h20;
    localparam logic [6:0] LINE1_END  = 7'h27;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE2_END  = 7'h67;

    // Addresses wrap line 1 -> line 2 -> line 1 in both directions.
    function automatic logic [6:0] lcd_addr_step(
        input logic [6:0] addr,
        input logic       inc
    );
        logic [6:0] r;
        if (inc) begin
            if (addr == LINE1_END)
                r = LINE2_BASE;
            else if (addr == LINE2_END)
                r = 7'h00;
            else
                r = addr + 7'd1;
        end else begin
            if (addr == 7'h00)
                r = LINE2_END;
            else if (addr == LINE2_BASE)
                r = LINE1_END;
            else
                r = addr - 7'd1;
        end
        return r;
    endfunction

    function automatic logic [6:0] lcd_addr_legal(
        input logic [6:0] addr
    );
        logic [6:0] r;
        if (addr > LINE1_END && addr < LINE2_BASE)
            r = LINE2_BASE;
        else if (addr > LINE2_END)
            r = 7'h00;
        else
            r = addr;
        return r;
    endfunction

endpackage

// File: rtl/lcd_e_edge.sv
// Bus synchroniser, E glitch filter and valid-fall detector.
// Emits the RS/DATA that were on the bus just before a qualified E fall.
module lcd_e_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_E_HIGH  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rs,
    input  logic       i_e,
    input  logic [3:0] i_data,
    output logic       o_fall,
    output logic       o_rs,
    output logic [3:0] o_nib
);

    localparam int CW = $clog2(MIN_E_HIGH + 1);
    localparam logic [CW-1:0] MAXC = CW'(MIN_E_HIGH);

    logic [SYNC_STAGES-1:0][5:0] r_sync;
    logic [CW-1:0]               r_cnt;
    logic                        r_e_d;
    logic                        r_rs_d;
    logic [3:0]                  r_data_d;
    logic [5:0]                  w_s;
    logic                        w_e;

    assign w_s = r_sync[SYNC_STAGES-1];
    assign w_e = w_s[4];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {i_rs, i_e, i_data}};
        end
    end

    // Count consecutive high samples, saturating at the filter length.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_e_d    <= 1'b0;
            r_rs_d   <= 1'b0;
            r_data_d <= 4'h0;
        end else begin
            if (!w_e)
                r_cnt <= '0;
            else if (r_cnt != MAXC)
                r_cnt <= r_cnt + 1'b1;
            r_e_d    <= w_e;
            r_rs_d   <= w_s[5];
            r_data_d <= w_s[3:0];
        end
    end

    assign o_fall = r_e_d & ~w_e & (r_cnt == MAXC);
    assign o_rs   = r_rs_d;
    assign o_nib  = r_data_d;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Responder end of the 4-bit LCD bus: init tracking, byte assembly,
// command/char dispatch and a mirror of the DDRAM address counter.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_E_HIGH  = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       LCD_RS,
    input  logic       LCD_E,
    input  logic [3:0] LCD_DATA,
    output logic       mode4,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       char_valid,
    output logic [7:0] char_code,
    output logic [6:0] char_addr,
    output logic       proto_err
);

    logic       w_fall;
    logic       w_rs;
    logic [3:0] w_nib;

    lcd_e_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .MIN_E_HIGH (MIN_E_HIGH)
    ) u_edge (
        .i_clk (Clk),
        .i_rst (Rst),
        .i_rs  (LCD_RS),
        .i_e   (LCD_E),
        .i_data(LCD_DATA),
        .o_fall(w_fall),
        .o_rs  (w_rs),
        .o_nib (w_nib)
    );

    lcd_state_e r_state;
    lcd_state_e w_state_nxt;
    logic [3:0] r_hi;
    logic       r_rs_hi;
    logic [6:0] r_addr;
    logic       r_inc;
    logic       r_mode4;
    logic       r_cmd_valid;
    logic [7:0] r_cmd_code;
    logic       r_char_valid;
    logic [7:0] r_char_code;
    logic [6:0] r_char_addr;
    logic       r_proto_err;

    logic [7:0] w_byte;
    logic       w_pair_ok;
    logic       w_init_go;
    logic       w_fset8;
    logic       w_dispatch;
    logic       w_cmd_stb;
    logic       w_char_stb;
    logic       w_perr_stb;
    logic [7:0] w_cmd_nxt;
    logic [7:0] w_char_nxt;
    logic [6:0] w_caddr_nxt;
    logic [6:0] w_addr_nxt;
    logic       w_inc_nxt;
    logic       w_mode4_nxt;

    assign w_byte     = {r_hi, w_nib};
    assign w_pair_ok  = (w_rs == r_rs_hi);
    assign w_init_go  = w_fall & ~w_rs & (w_nib == 4'h2);
    assign w_fset8    = (w_byte[7:5] == 3'b001) & w_byte[4];
    assign w_dispatch = (r_state == LO) & w_fall & w_pair_ok;

    always_ff @(posedge Clk) begin
        if (Rst)
            r_state <= INIT8;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            INIT8:   if (w_init_go) w_state_nxt = HI;
            HI:      if (w_fall) w_state_nxt = LO;
            LO: begin
                if (w_fall)
                    w_state_nxt = (w_pair_ok & ~w_rs & w_fset8) ? INIT8 : HI;
            end
            default: w_state_nxt = INIT8;
        endcase
    end

    always_comb begin
        w_cmd_stb   = 1'b0;
        w_char_stb  = 1'b0;
        w_perr_stb  = 1'b0;
        w_cmd_nxt   = r_cmd_code;
        w_char_nxt  = r_char_code;
        w_caddr_nxt = r_char_addr;
        w_addr_nxt  = r_addr;
        w_inc_nxt   = r_inc;
        w_mode4_nxt = r_mode4;
        if (r_state == INIT8 && w_init_go) begin
            w_cmd_stb   = 1'b1;
            w_cmd_nxt   = CMD_FSET4;
            w_mode4_nxt = 1'b1;
        end else if (r_state == LO && w_fall && !w_pair_ok) begin
            w_perr_stb = 1'b1;
        end else if (w_dispatch && w_rs) begin
            w_char_stb  = 1'b1;
            w_char_nxt  = w_byte;
            w_caddr_nxt = r_addr;
            w_addr_nxt  = lcd_addr_step(r_addr, r_inc);
        end else if (w_dispatch) begin
            w_cmd_stb = 1'b1;
            w_cmd_nxt = w_byte;
            unique case (1'b1)
                w_byte[7]:
                    w_addr_nxt = lcd_addr_legal(w_byte[6:0]);
                w_byte[7:5] == 3'b001:
                    if (w_byte[4]) w_mode4_nxt = 1'b0;
                w_byte[7:2] == 6'b000001:
                    w_inc_nxt = w_byte[1];
                w_byte[7:1] == CMD_HOME[7:1]:
                    w_addr_nxt = 7'h00;
                w_byte == CMD_CLEAR: begin
                    w_addr_nxt = 7'h00;
                    w_inc_nxt  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_hi         <= 4'h0;
            r_rs_hi      <= 1'b0;
            r_addr       <= 7'h00;
            r_inc        <= 1'b1;
            r_mode4      <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_code   <= 8'h00;
            r_char_valid <= 1'b0;
            r_char_code  <= 8'h00;
            r_char_addr  <= 7'h00;
            r_proto_err  <= 1'b0;
        end else begin
            if (r_state == HI && w_fall) begin
                r_hi    <= w_nib;
                r_rs_hi <= w_rs;
            end
            r_addr       <= w_addr_nxt;
            r_inc        <= w_inc_nxt;
            r_mode4      <= w_mode4_nxt;
            r_cmd_valid  <= w_cmd_stb;
            r_cmd_code   <= w_cmd_nxt;
            r_char_valid <= w_char_stb;
            r_char_code  <= w_char_nxt;
            r_char_addr  <= w_caddr_nxt;
            r_proto_err  <= w_perr_stb;
        end
    end

    assign mode4      = r_mode4;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_code   = r_cmd_code;
    assign char_valid = r_char_valid;
    assign char_code  = r_char_code;
    assign char_addr  = r_char_addr;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: directed table, corner sequences and
// randomized nibble traffic checked against an event-level model.
module tb_lcd_bus_receiver;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       LCD_RS;
    logic       LCD_E;
    logic [3:0] LCD_DATA;
    logic       mode4;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       char_valid;
    logic [7:0] char_code;
    logic [6:0] char_addr;
    logic       proto_err;

    lcd_bus_receiver #(
        .SYNC_STAGES(2),
        .MIN_E_HIGH (2)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .LCD_RS    (LCD_RS),
        .LCD_E     (LCD_E),
        .LCD_DATA  (LCD_DATA),
        .mode4     (mode4),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .char_valid(char_valid),
        .char_code (char_code),
        .char_addr (char_addr),
        .proto_err (proto_err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] code;
        logic [6:0] addr;
    } ev_t;

    typedef struct {
        logic       rs;
        logic [7:0] b;
        ev_t        exp;
    } vec_t;

    localparam logic [1:0] K_CMD = 2'd0;
    localparam logic [1:0] K_CHR = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    ev_t  dut_q[$];
    ev_t  mdl_q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    bit         m_mode4;
    bit         m_have_hi;
    bit         m_hi_rs;
    logic [3:0] m_hi;
    logic [6:0] m_addr;
    bit         m_inc;

    always @(negedge Clk) begin
        int ns;
        ns = int'(cmd_valid) + int'(char_valid) + int'(proto_err);
        if (ns > 1) begin
            n_vec++;
            n_bad++;
            $display("FAIL overlap: %0d strobes in one cycle, want at most 1", ns);
        end
        if (cmd_valid)  dut_q.push_back({K_CMD, cmd_code, 7'h00});
        if (char_valid) dut_q.push_back({K_CHR, char_code, char_addr});
        if (proto_err)  dut_q.push_back({K_ERR, 8'h00, 7'h00});
    end

    // Display positions 0..79 laid out as line 1 then line 2, circular.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input bit inc);
        int p;
        p = (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
        p = inc ? (p + 1) % 80 : (p + 79) % 80;
        return (p < 40) ? 7'(p) : 7'(p - 40 + 64);
    endfunction

    function automatic logic [6:0] legal_addr(input logic [6:0] a);
        if (a >= 7'h28 && a < 7'h40) return 7'h40;
        if (a >= 7'h68) return 7'h00;
        return a;
    endfunction

    task automatic model_reset();
        m_mode4   = 0;
        m_have_hi = 0;
        m_hi_rs   = 0;
        m_hi      = 4'h0;
        m_addr    = 7'h00;
        m_inc     = 1;
    endtask

    task automatic model_byte(input logic rs, input logic [7:0] b);
        if (rs) begin
            mdl_q.push_back({K_CHR, b, m_addr});
            m_addr = step_addr(m_addr, m_inc);
        end else begin
            mdl_q.push_back({K_CMD, b, 7'h00});
            if (b == 8'h01) begin
                m_addr = 7'h00;
                m_inc  = 1;
            end else if (b == 8'h02 || b == 8'h03) begin
                m_addr = 7'h00;
            end else if (b >= 8'h04 && b <= 8'h07) begin
                m_inc = b[1];
            end else if (b >= 8'h20 && b <= 8'h3F) begin
                if (b[4]) m_mode4 = 0;
            end else if (b >= 8'h80) begin
                m_addr = legal_addr(b[6:0]);
            end
        end
    endtask

    task automatic model_nib(input logic rs, input logic [3:0] n);
        if (!m_mode4) begin
            if (!rs && n == 4'h2) begin
                m_mode4   = 1;
                m_have_hi = 0;
                mdl_q.push_back({K_CMD, 8'h20, 7'h00});
            end
        end else if (!m_have_hi) begin
            m_have_hi = 1;
            m_hi      = n;
            m_hi_rs   = rs;
        end else begin
            m_have_hi = 0;
            if (rs != m_hi_rs)
                mdl_q.push_back({K_ERR, 8'h00, 7'h00});
            else
                model_byte(rs, {m_hi, n});
        end
    endtask

    task automatic send_nib(input logic rs, input logic [3:0] n, input int hi_len);
        @(negedge Clk);
        LCD_RS   = rs;
        LCD_DATA = n;
        LCD_E    = 1'b1;
        repeat (hi_len) @(negedge Clk);
        LCD_E = 1'b0;
        repeat (4) @(negedge Clk);
        if (hi_len >= 2) model_nib(rs, n);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, input int hi_len);
        send_nib(rs, b[7:4], hi_len);
        send_nib(rs, b[3:0], hi_len);
    endtask

    task automatic check_events(input string name);
        n_vec++;
        if (dut_q.size() != mdl_q.size()) begin
            n_bad++;
            $display("FAIL %s: event count got %0d want %0d",
                     name, dut_q.size(), mdl_q.size());
        end else begin
            foreach (dut_q[i]) begin
                n_vec++;
                if (dut_q[i] !== mdl_q[i]) begin
                    n_bad++;
                    $display("FAIL %s[%0d]: got kind=%0d code=%h addr=%h want kind=%0d code=%h addr=%h",
                             name, i, dut_q[i].kind, dut_q[i].code, dut_q[i].addr,
                             mdl_q[i].kind, mdl_q[i].code, mdl_q[i].addr);
                end
            end
        end
        dut_q.delete();
        mdl_q.delete();
    endtask

    task automatic check_mode4(input string name);
        n_vec++;
        if (mode4 !== m_mode4) begin
            n_bad++;
            $display("FAIL %s: mode4 got %b want %b", name, mode4, m_mode4);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [26:0] v;
        v = {mode4, cmd_valid, cmd_code, char_valid, char_code, char_addr, proto_err};
        n_vec++;
        if (v !== 27'h0) begin
            n_bad++;
            $display("FAIL %s: outputs got %h want 0", name, v);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst   = 1'b1;
        LCD_E = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        model_reset();
    endtask

    task automatic add_vec(input logic rs, input logic [7:0] b,
                           input logic [1:0] k, input logic [6:0] a);
        vec_t v;
        v.rs  = rs;
        v.b   = b;
        v.exp = {k, b, a};
        tbl.push_back(v);
    endtask

    initial begin
        logic       rs;
        logic       mis;
        logic [7:0] b;
        int         hl;

        Rst      = 1'b1;
        LCD_RS   = 1'b0;
        LCD_E    = 1'b0;
        LCD_DATA = 4'h0;
        model_reset();
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        check_all_zero("reset");

        send_nib(1'b0, 4'h3, 4);
        send_nib(1'b0, 4'h3, 4);
        send_nib(1'b0, 4'h3, 4);
        send_nib(1'b0, 4'h2, 4);
        check_events("init");
        check_mode4("init_mode4");

        // Latency: strobe lands SYNC_STAGES+1 clocks after the pin falls.
        send_nib(1'b1, 4'h4, 4);
        @(negedge Clk);
        LCD_RS   = 1'b1;
        LCD_DATA = 4'h1;
        LCD_E    = 1'b1;
        repeat (4) @(negedge Clk);
        LCD_E = 1'b0;
        repeat (2) @(negedge Clk);
        n_vec++;
        if (char_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: char_valid got %b want 0", char_valid);
        end
        @(negedge Clk);
        n_vec++;
        if ({char_valid, char_code, char_addr} !== {1'b1, 8'h41, 7'h00}) begin
            n_bad++;
            $display("FAIL latency: got v=%b code=%h addr=%h want v=1 code=41 addr=00",
                     char_valid, char_code, char_addr);
        end
        @(negedge Clk);
        model_nib(1'b1, 4'h1);
        check_events("latency");

        add_vec(1'b0, 8'hC0, K_CMD, 7'h00);
        add_vec(1'b1, 8'h42, K_CHR, 7'h40);
        add_vec(1'b1, 8'h43, K_CHR, 7'h41);
        add_vec(1'b0, 8'hA7, K_CMD, 7'h00);
        add_vec(1'b1, 8'h61, K_CHR, 7'h27);
        add_vec(1'b1, 8'h62, K_CHR, 7'h40);
        add_vec(1'b0, 8'h04, K_CMD, 7'h00);
        add_vec(1'b0, 8'h80, K_CMD, 7'h00);
        add_vec(1'b1, 8'h63, K_CHR, 7'h00);
        add_vec(1'b1, 8'h64, K_CHR, 7'h67);
        add_vec(1'b0, 8'h01, K_CMD, 7'h00);
        add_vec(1'b1, 8'h65, K_CHR, 7'h00);
        add_vec(1'b0, 8'hB0, K_CMD, 7'h00);
        add_vec(1'b1, 8'h66, K_CHR, 7'h40);
        add_vec(1'b0, 8'h03, K_CMD, 7'h00);
        add_vec(1'b1, 8'h67, K_CHR, 7'h00);
        add_vec(1'b0, 8'hFF, K_CMD, 7'h00);
        add_vec(1'b1, 8'h68, K_CHR, 7'h00);
        add_vec(1'b0, 8'hE7, K_CMD, 7'h00);
        add_vec(1'b1, 8'h69, K_CHR, 7'h67);
        add_vec(1'b1, 8'h6A, K_CHR, 7'h00);
        add_vec(1'b0, 8'h06, K_CMD, 7'h00);
        add_vec(1'b0, 8'h08, K_CMD, 7'h00);
        add_vec(1'b1, 8'h6B, K_CHR, 7'h01);

        foreach (tbl[i]) begin
            send_byte(tbl[i].rs, tbl[i].b, 3);
            n_vec++;
            if (dut_q.size() != 1) begin
                n_bad++;
                $display("FAIL table[%0d]: %0d events, want 1 (code=%h)",
                         i, dut_q.size(), tbl[i].b);
            end else if (dut_q[0] !== tbl[i].exp) begin
                n_bad++;
                $display("FAIL table[%0d]: got kind=%0d code=%h addr=%h want kind=%0d code=%h addr=%h",
                         i, dut_q[0].kind, dut_q[0].code, dut_q[0].addr,
                         tbl[i].exp.kind, tbl[i].exp.code, tbl[i].exp.addr);
            end
            dut_q.delete();
            mdl_q.delete();
        end

        send_nib(1'b1, 4'h5, 1);
        check_events("glitch_none");
        send_byte(1'b1, 8'h48, 3);
        check_events("glitch_after");

        send_nib(1'b0, 4'h4, 3);
        send_nib(1'b1, 4'h1, 3);
        check_events("proto");
        send_byte(1'b1, 8'h50, 3);
        check_events("proto_after");

        send_nib(1'b1, 4'h3, 3);
        do_reset();
        check_all_zero("midpair_reset");
        send_nib(1'b0, 4'h2, 3);
        check_events("reinit");
        check_mode4("reinit_mode4");
        send_byte(1'b0, 8'h30, 3);
        check_events("fset8");
        check_mode4("fset8_mode4");
        send_nib(1'b0, 4'h2, 3);
        check_events("reinit2");

        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 5) == 0)
                send_nib(1'($urandom), 4'($urandom), 1);
            rs  = 1'($urandom);
            b   = 8'($urandom);
            mis = ($urandom_range(0, 9) == 0);
            hl  = $urandom_range(2, 5);
            send_nib(rs, b[7:4], hl);
            send_nib(mis ? ~rs : rs, b[3:0], hl);
            check_events("rand");
            check_mode4("rand_mode4");
            if (!m_mode4) send_nib(1'b0, 4'h2, 2);
        end
        check_events("rand_tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
